// File: rtl/da_odd_dct_mac.sv
// da_odd_dct_mac: bit-serial distributed-arithmetic MAC for one odd DCT-8
// output (Z1/Z3/Z5/Z7). A single 16-entry-per-row coefficient LUT is
// selected at run time by row_sel. Operands are consumed MSB first, one bit
// of each of d0..d3 per cycle.
// Optional feature: define DA_ROUND_EN to round z to an integer
// ((acc + 2^13) >>> 14). Without it z carries full Q2.14 precision.
module da_odd_dct_mac #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 16,
  localparam int ACC_W = COEF_W + DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] d0,
  input  logic signed [DATA_W-1:0] d1,
  input  logic signed [DATA_W-1:0] d2,
  input  logic signed [DATA_W-1:0] d3,
  input  logic [1:0]               row_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  z
);

  localparam int CNT_W = $clog2(DATA_W);

  // Half-cosine coefficients in Q2.14
  localparam logic signed [COEF_W-1:0] H1 = 16'sd8035;
  localparam logic signed [COEF_W-1:0] H3 = 16'sd6811;
  localparam logic signed [COEF_W-1:0] H5 = 16'sd4551;
  localparam logic signed [COEF_W-1:0] H7 = 16'sd1598;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed coefficient k_idx of the selected output row
  function automatic logic signed [COEF_W-1:0] coef_k(input logic [1:0] row,
                                                       input logic [1:0] idx);
    logic signed [COEF_W-1:0] k;
    case ({row, idx})
      4'd0:    k = H1;
      4'd1:    k = H3;
      4'd2:    k = H5;
      4'd3:    k = H7;
      4'd4:    k = H3;
      4'd5:    k = -H7;
      4'd6:    k = -H1;
      4'd7:    k = -H5;
      4'd8:    k = H5;
      4'd9:    k = -H1;
      4'd10:   k = H7;
      4'd11:   k = H3;
      4'd12:   k = H7;
      4'd13:   k = -H5;
      4'd14:   k = H3;
      4'd15:   k = -H1;
      default: k = {COEF_W{1'b0}};
    endcase
    return k;
  endfunction

  // DA LUT word: sum of k_i for every set address bit (addr[3] <-> d0)
  function automatic logic signed [COEF_W-1:0] lut_word(input logic [1:0] row,
                                                         input logic [3:0] addr);
    logic signed [COEF_W-1:0] s;
    s = (addr[3] ? coef_k(row, 2'd0) : {COEF_W{1'b0}})
      + (addr[2] ? coef_k(row, 2'd1) : {COEF_W{1'b0}})
      + (addr[1] ? coef_k(row, 2'd2) : {COEF_W{1'b0}})
      + (addr[0] ? coef_k(row, 2'd3) : {COEF_W{1'b0}});
    return s;
  endfunction

  state_t                    state_r, next_state_s;
  logic                      in_ready_r, out_valid_r;
  logic signed [DATA_W-1:0]  d0_r, d1_r, d2_r, d3_r;
  logic [1:0]                row_r;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic                      load_s, step_s;
  logic [3:0]                addr_s;
  logic signed [COEF_W-1:0]  lut_s;
  logic signed [ACC_W-1:0]   lut_ext_s, term_s, acc_next_s;

  // Bit-slice address, LUT lookup and signed accumulate step
  always_comb begin
    addr_s     = {d0_r[cnt_r], d1_r[cnt_r], d2_r[cnt_r], d3_r[cnt_r]};
    lut_s      = lut_word(row_r, addr_s);
    lut_ext_s  = {{(ACC_W-COEF_W){lut_s[COEF_W-1]}}, lut_s};
    if (cnt_r == CNT_W'(DATA_W-1)) begin
      term_s = -lut_ext_s;
    end else begin
      term_s = lut_ext_s;
    end
    acc_next_s = (acc_r <<< 1) + term_s;
  end

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Operand latch, bit counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_r  <= {DATA_W{1'b0}};
      d1_r  <= {DATA_W{1'b0}};
      d2_r  <= {DATA_W{1'b0}};
      d3_r  <= {DATA_W{1'b0}};
      row_r <= 2'd0;
      cnt_r <= {CNT_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else if (load_s) begin
      d0_r  <= d0;
      d1_r  <= d1;
      d2_r  <= d2;
      d3_r  <= d3;
      row_r <= row_sel;
      cnt_r <= CNT_W'(DATA_W-1);
      acc_r <= {ACC_W{1'b0}};
    end else if (step_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
      acc_r <= acc_next_s;
    end else begin
      cnt_r <= cnt_r;
      acc_r <= acc_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

`ifdef DA_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-14){1'b0}}, 14'h2000};
  logic signed [ACC_W-1:0] rnd_sum_s;
  assign rnd_sum_s = acc_r + RND_HALF;
  assign z         = rnd_sum_s >>> 5'd14;
`else
  assign z = acc_r;
`endif

endmodule

// File: tb/tb_da_odd_dct_mac.sv
// Self-checking bench for da_odd_dct_mac: directed test-plan vectors,
// backpressure, mid-RUN reset and randomized operands against an
// arithmetic dot-product reference.
module tb_da_odd_dct_mac;

  localparam int DATA_W = 12;
  localparam int COEF_W = 16;
  localparam int ACC_W  = COEF_W + DATA_W + 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] d0, d1, d2, d3;
  logic [1:0]               row_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  z;

  int n_checks = 0;
  int n_errors = 0;

  da_odd_dct_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .row_sel(row_sel),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: z = sum k_i*d_i over the row's coefficient vector
  function automatic longint model_z(input int row, input int a0, input int a1,
                                     input int a2, input int a3);
    int kt [4][4] = '{'{8035, 6811, 4551, 1598},
                      '{6811, -1598, -8035, -4551},
                      '{4551, -8035, 1598, 6811},
                      '{1598, -4551, 6811, -8035}};
    longint s;
    s = longint'(kt[row][0]) * a0 + longint'(kt[row][1]) * a1
      + longint'(kt[row][2]) * a2 + longint'(kt[row][3]) * a3;
`ifdef DA_ROUND_EN
    s = (s + 64'sd8192) >>> 14;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, " in_ready"}, longint'(in_ready), 64'sd1);
  endtask

  task automatic present(input int row, input int a0, input int a1,
                         input int a2, input int a3);
    row_sel  = 2'(row);
    d0       = DATA_W'(a0);
    d1       = DATA_W'(a1);
    d2       = DATA_W'(a2);
    d3       = DATA_W'(a3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // One full transaction with out_ready high; checks latency, z, and turnaround
  task automatic do_op(input string tag, input int row, input int a0,
                       input int a1, input int a2, input int a3);
    int n;
    longint exp;
    exp = model_z(row, a0, a1, a2, a3);
    out_ready = 1'b1;
    wait_ready(tag);
    present(row, a0, a1, a2, a3);
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, " latency"}, longint'(n), longint'(DATA_W + 1));
    check_val({tag, " z"}, longint'(z), exp);
    tick();
    check_val({tag, " in_ready after"}, longint'(in_ready), 64'sd1);
    check_val({tag, " out_valid after"}, longint'(out_valid), 64'sd0);
  endtask

  initial begin
    int n, hits;
    longint exp, z_hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; row_sel = 2'd0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    repeat (3) tick();
    check_val("rst out_valid", longint'(out_valid), 64'sd0);
    check_val("rst z", longint'(z), model_z(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    check_val("post-rst in_ready", longint'(in_ready), 64'sd1);
    check_val("post-rst out_valid", longint'(out_valid), 64'sd0);

    // Directed test-plan vectors
    do_op("r0 d=1000", 0, 1, 0, 0, 0);
    do_op("r0 d=-1000", 0, -1, 0, 0, 0);
    do_op("r0 d=1111", 0, 1, 1, 1, 1);
    do_op("r1 d=1111", 1, 1, 1, 1, 1);
    do_op("r3 d=0001", 3, 0, 0, 0, 1);
    do_op("r0 min", 0, -2048, -2048, -2048, -2048);
    do_op("r0 max", 0, 2047, 2047, 2047, 2047);
    do_op("r2 mix", 2, -2048, 2047, -2048, 2047);
    do_op("r0 d=2000", 0, 2, 0, 0, 0);
    do_op("r0 d=-2000", 0, -2, 0, 0, 0);

    // Backpressure: hold DONE, offer a new input that must be ignored
    exp = model_z(1, 300, -700, 45, -1999);
    wait_ready("bp");
    out_ready = 1'b0;
    present(1, 300, -700, 45, -1999);
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_val("bp latency", longint'(n), longint'(DATA_W + 1));
    check_val("bp z", longint'(z), exp);
    z_hold = longint'(z);
    row_sel = 2'd3; d0 = 12'sd5; d1 = 12'sd6; d2 = 12'sd7; d3 = 12'sd8;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp hold out_valid", longint'(out_valid), 64'sd1);
      check_val("bp hold z", longint'(z), z_hold);
      check_val("bp hold in_ready", longint'(in_ready), 64'sd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("bp release in_ready", longint'(in_ready), 64'sd1);
    check_val("bp release out_valid", longint'(out_valid), 64'sd0);
    do_op("after bp", 0, 1, 0, 0, 0);

    // Reset in the middle of RUN: partial result must never be emitted
    wait_ready("mid-rst");
    present(2, 1234, -5, 77, -800);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check_val("mid-rst out_valid", longint'(out_valid), 64'sd0);
    check_val("mid-rst z", longint'(z), model_z(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) hits++;
    end
    check_val("mid-rst no emit", longint'(hits), 64'sd0);
    do_op("after mid-rst", 0, 1, 0, 0, 0);

    // Randomized operands and rows
    for (int i = 0; i < 40; i++) begin
      int r, a0, a1, a2, a3;
      logic signed [DATA_W-1:0] t;
      r  = int'($urandom_range(3, 0));
      t  = DATA_W'($urandom_range(4095, 0)); a0 = int'(t);
      t  = DATA_W'($urandom_range(4095, 0)); a1 = int'(t);
      t  = DATA_W'($urandom_range(4095, 0)); a2 = int'(t);
      t  = DATA_W'($urandom_range(4095, 0)); a3 = int'(t);
      do_op($sformatf("rand%0d", i), r, a0, a1, a2, a3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/da_odd_dct_mac.md
# da_odd_dct_mac

Bit-serial distributed-arithmetic multiply-accumulate engine computing one odd DCT-8 output (Z1, Z3, Z5 or Z7) from four butterfly differences. Replaces the fixed per-row, 8-entry coefficient ROMs with a single 16-entry-per-row coefficient LUT that is selectable at run time. Sits after the DCT input butterfly stage; one instance per odd output lane. Uses a valid/ready handshake on input and output.

## Interface
- DATA_W, 12, signed width of each difference input d0..d3 (≥4)
- COEF_W, 16, LUT word width, signed Q2.14 (fixed)
- ACC_W, COEF_W+DATA_W+2, localparam, accumulator and output width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- in_valid  in  1  d0..d3 and row_sel are valid
- in_ready  out  1  engine idle, accepts an input
- d0, d1, d2, d3  in  DATA_W each  signed butterfly differences (x0−x7, x1−x6, x2−x5, x3−x4)
- row_sel  in  2  0→Z1, 1→Z3, 2→Z5, 3→Z7
- out_valid  out  1  z valid; held until accepted
- out_ready  in  1  downstream accepts z
- z  out  ACC_W  signed result

## Operation
- Half-coefficients, Q2.14 integers: h1=8035 (0.5·c1), h3=6811, h5=4551, h7=1598.
- Per-row signed coefficient vectors (k0,k1,k2,k3): row0 (h1,h3,h5,h7); row1 (h3,−h7,−h1,−h5); row2 (h5,−h1,h7,h3); row3 (h7,−h5,h3,−h1).
- LUT address a = {d0[b],d1[b],d2[b],d3[b]} (d0 bit is address MSB); LUT[row][a] = sum of k_i for each set bit, i.e. a3·k0 + a2·k1 + a1·k2 + a0·k3; LUT[row][0]=0. Purely combinational, 64 constant words.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: latch d0..d3 and row_sel; clear acc; set bit counter b=DATA_W−1; go to RUN.
  - RUN: in_ready=0. Each cycle: acc ← (acc<<1) + L, where L = −LUT for b=DATA_W−1 (sign bit), +LUT otherwise; LUT is sign-extended to ACC_W. Decrement b; after b=0 processed, go to DONE.
  - DONE: out_valid=1, z driven from acc. On out_ready: go to IDLE.
- Result: z = Σ_i k_i·d_i exactly (Q2.14 scaling, 14 fractional bits); no overflow possible within ACC_W.
- Inputs ignored outside IDLE; latched operands are stable across RUN.

## Timing
- Reset values: in_ready=1 after reset release (0 while rst_n low is not required; in_ready=1 during reset is acceptable); out_valid=0, z=0, acc=0, state IDLE.
- Accept at edge T0 (in_valid & in_ready). RUN occupies DATA_W cycles (T1..T_DATA_W). out_valid rises after edge T_DATA_W; latency = DATA_W+1 cycles from accept to first out_valid.
- Throughput: one result per DATA_W+2 cycles with out_ready tied high; in_ready returns 1 on the cycle after out_valid&out_ready.
- Backpressure: out_ready low holds DONE; z and out_valid stable, in_ready stays 0.
- in_valid and out handshake cannot coincide (in_ready=0 in DONE); no bypass path.
- rst_n asserted mid-RUN or mid-DONE: immediately IDLE, acc/z cleared, out_valid=0; the partial result is discarded and never emitted.

## Configuration
- DA_ROUND_EN defined: z = (acc + 8192) >>> 14 (round half up to integer), sign-extended to ACC_W; applied combinationally at the output, latency unchanged.
- Not defined: z = acc, full Q2.14 precision.

## Test plan
- DATA_W=12, row_sel=0, d=(1,0,0,0) -> z=8035, out_valid exactly 13 cycles after accept; (−1,0,0,0) -> z=−8035.
- row_sel=0, d=(1,1,1,1) -> 20995; row_sel=1, d=(1,1,1,1) -> −7373; row_sel=3, d=(0,0,0,1) -> −8035.
- Extremes: row_sel=0, all d=−2048 -> −42997760; all d=2047 -> 42976765; no wrap.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> z, out_valid stable, in_ready=0, new in_valid ignored; release -> in_ready=1 next cycle.
- Reset mid-RUN (cycle 6 of 12) -> out_valid never asserts for that operand; next input d=(1,0,0,0) row0 gives 8035.
- DA_ROUND_EN: d=(2,0,0,0) row0 -> z=1; (1,0,0,0) -> z=0; (−2,0,0,0) -> z=−1.
